trace_tap: RTL and testbench
============================

# trace_tap

Core-side producer for the instruction trace port. Accepts retirement events and late (long-latency) register writebacks from the pipeline, merges or serializes them into a small FIFO, and drives at most one trace record per cycle onto the `valid/pc/inst/rdv/rd_x/rd_data` interface consumed by the trace printer. It sits between the core's commit stage and the simulation trace sink. It never reorders events.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `ret_valid`  in  1  instruction retires this cycle.
- `ret_ready`  out  1  retire accepted when `ret_valid & ret_ready`.
- `ret_pc`  in  32  retired PC.
- `ret_inst`  in  32  retired instruction word.
- `ret_rdv`  in  1  retiring instruction writes a register this cycle.
- `ret_rd`  in  5  destination register.
- `ret_data`  in  32  write data.
- `wb_valid`  in  1  late writeback (e.g. load) this cycle.
- `wb_ready`  out  1  writeback accepted when `wb_valid & wb_ready`.
- `wb_rd`  in  5  late destination register.
- `wb_data`  in  32  late write data.
- `valid`  out  1  trace record carries an instruction.
- `pc`, `inst`  out  32 each  instruction fields, meaningful when `valid`.
- `rdv`  out  1  trace record carries a register write.
- `rd_x`  out  5  written register, meaningful when `rdv`.
- `rd_data`  out  32  written data, meaningful when `rdv`.

## Operation
- FIFO record: `{iv, pc, inst, wv, rd, data}`. Storage `DEPTH` entries; read/write pointers `log2(DEPTH)` bits, wrap modulo `DEPTH`; `count` is `log2(DEPTH)+1` bits.
- `ret_ready = wb_ready = (DEPTH - count) >= 2`. Combinational from registered `count` only; no dependence on valids.
- Push rules per cycle (accepted events only):
  - retire only: one record `{1, ret_pc, ret_inst, ret_rdv, ret_rd, ret_data}`.
  - wb only: one record `{0, x, x, 1, wb_rd, wb_data}`.
  - both, `ret_rdv=0`: merged single record `{1, ret_pc, ret_inst, 1, wb_rd, wb_data}`.
  - both, `ret_rdv=1`: two records: wb record first, then retire record (late writeback belongs to an older instruction).
- Pop: at each edge, if `count != 0` (pre-edge value), head loads output registers and pointer advances; else output registers load `valid=0, rdv=0`, data fields hold.
- Push and pop same edge: `count` updates by pushes − pop. Entries pushed at an edge are never popped at that same edge.
- Unused fields of a record (`pc/inst` when `iv=0`, `rd/data` when `wv=0`) drive 0.

## Timing
- Reset (async assert, sync-safe deassert): `valid=0, rdv=0, pc=0, inst=0, rd_x=0, rd_data=0`, pointers and `count` = 0, so `ret_ready=wb_ready=1`.
- Latency: event accepted at edge k appears on outputs after edge k+1 when FIFO was empty; each older record adds one cycle.
- Throughput: one record out per cycle; sustained retire+wb with `ret_rdv=1` (two pushes/cycle) fills FIFO and deasserts ready.
- Full: `count ≥ DEPTH-1` → both readies low; inputs ignored. Overflow impossible.
- Empty: outputs `valid=rdv=0` the next cycle.
- Reset asserted mid-stream: all pending records discarded, outputs zero immediately (asynchronous).

## Configuration
- `TRACE_X0_FILTER_EN` defined: any write with rd = 0 is dropped at push: retire `wv` forced 0; a wb-only event to x0 pushes nothing; both-valid with wb to x0 becomes retire-only.
- Undefined: writes to x0 are traced like any other register.

## Test plan
- Reset: hold `reset_n=0` with all valids 1 → outputs all 0, `ret_ready=wb_ready=1`; release → first record appears no earlier than 2 edges after first accepted event.
- Single retire pc=0x80000000 inst=0x00500093 rdv rd=1 data=5 → one cycle later-plus-one: `valid=1 rdv=1 rd_x=1 rd_data=0x5`, next cycle `valid=0 rdv=0`.
- Merge: retire (pc=0x80000004, inst=0x0000a103, rdv=0) with wb rd=3 data=0xdeadbeef same cycle → single record `valid=1 rdv=1 rd_x=3`.
- Split: retire rdv rd=4 data=0x11 with wb rd=2 data=0x22 → two consecutive records: first `valid=0 rdv=1 rd_x=2 data=0x22`, then `valid=1 rd_x=4 data=0x11`.
- Back-pressure with DEPTH=4: five consecutive split cycles → readies drop when count=3, no record lost, all records drain in order, readies return when count ≤ 2.
- With `TRACE_X0_FILTER_EN`: wb rd=0 alone → no output; retire `li x0` → `valid=1 rdv=0`. Without: both show `rdv=1 rd_x=0`.

Source files
------------

// File: rtl/trace_tap_if.sv
// Trace tap bundle: retirement events, late writebacks and the outgoing trace record.
// master: the pipeline/sink side (drives ret_*/wb_*, observes readies and trace outputs).
// slave:  the trace_tap side (observes ret_*/wb_*, drives readies and trace outputs).
interface trace_tap_if;
  // retirement channel
  logic        ret_valid;
  logic        ret_ready;
  logic [31:0] ret_pc;
  logic [31:0] ret_inst;
  logic        ret_rdv;
  logic [4:0]  ret_rd;
  logic [31:0] ret_data;
  // late writeback channel
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // trace record out
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        rdv;
  logic [4:0]  rd_x;
  logic [31:0] rd_data;

  modport master (
    output ret_valid, ret_pc, ret_inst, ret_rdv, ret_rd, ret_data,
    output wb_valid, wb_rd, wb_data,
    input  ret_ready, wb_ready,
    input  valid, pc, inst, rdv, rd_x, rd_data
  );

  modport slave (
    input  ret_valid, ret_pc, ret_inst, ret_rdv, ret_rd, ret_data,
    input  wb_valid, wb_rd, wb_data,
    output ret_ready, wb_ready,
    output valid, pc, inst, rdv, rd_x, rd_data
  );
endinterface

// File: rtl/trace_tap.sv
// trace_tap: merges/serializes retire and late-writeback events into a DEPTH-entry FIFO
// and emits at most one registered trace record per cycle (2-edge latency when empty).
// Ports: clk, reset_n (async active-low), bus (trace_tap_if.slave: ret_*, wb_*, trace record).
// Readies depend only on the registered count (low when fewer than 2 slots free).
// Optional macro TRACE_X0_FILTER_EN: drop register writes to x0 at push time.
module trace_tap #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  trace_tap_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rec_t          out_q, out_d;

  logic ready;
  logic ret_acc, wb_acc;
  logic ret_wv, wb_wv;
  rec_t rec0, rec1;
  logic [1:0] n_push;
  logic pop;

  // Two free slots are always reserved so a split (two-record) push can never overflow.
  assign ready         = (CW'(DEPTH) - count_q) >= CW'(2);
  assign bus.ret_ready = ready;
  assign bus.wb_ready  = ready;

  assign ret_acc = bus.ret_valid & ready;
  assign wb_acc  = bus.wb_valid & ready;

`ifdef TRACE_X0_FILTER_EN
  assign ret_wv = bus.ret_rdv & (bus.ret_rd != 5'd0);
  assign wb_wv  = wb_acc & (bus.wb_rd != 5'd0);
`else
  assign ret_wv = bus.ret_rdv;
  assign wb_wv  = wb_acc;
`endif

  // Build up to two records for this cycle. When both events carry a write, the
  // late writeback belongs to an older instruction, so it goes first.
  always_comb begin
    rec0   = '0;
    rec1   = '0;
    n_push = 2'd0;
    if (ret_acc && wb_wv && !ret_wv) begin
      rec0   = '{iv: 1'b1, pc: bus.ret_pc, inst: bus.ret_inst,
                 wv: 1'b1, rd: bus.wb_rd, data: bus.wb_data};
      n_push = 2'd1;
    end else if (ret_acc && wb_wv) begin
      rec0   = '{iv: 1'b0, pc: 32'd0, inst: 32'd0,
                 wv: 1'b1, rd: bus.wb_rd, data: bus.wb_data};
      rec1   = '{iv: 1'b1, pc: bus.ret_pc, inst: bus.ret_inst,
                 wv: 1'b1, rd: bus.ret_rd, data: bus.ret_data};
      n_push = 2'd2;
    end else if (ret_acc) begin
      rec0   = '{iv: 1'b1, pc: bus.ret_pc, inst: bus.ret_inst,
                 wv: ret_wv, rd: ret_wv ? bus.ret_rd : 5'd0,
                 data: ret_wv ? bus.ret_data : 32'd0};
      n_push = 2'd1;
    end else if (wb_wv) begin
      rec0   = '{iv: 1'b0, pc: 32'd0, inst: 32'd0,
                 wv: 1'b1, rd: bus.wb_rd, data: bus.wb_data};
      n_push = 2'd1;
    end
  end

  // Pop reads pre-edge storage, so entries written at this edge are never popped at it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    pop      = (count_q != '0);

    if (n_push != 2'd0) mem_d[wr_ptr_q] = rec0;
    if (n_push == 2'd2) mem_d[wr_ptr_q + AW'(1)] = rec1;
    wr_ptr_d = wr_ptr_q + AW'(n_push);

    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      // Idle cycle: flags drop, data fields hold their last value.
      out_d.iv = 1'b0;
      out_d.wv = 1'b0;
    end

    count_d = count_q + CW'(n_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  assign bus.valid   = out_q.iv;
  assign bus.pc      = out_q.pc;
  assign bus.inst    = out_q.inst;
  assign bus.rdv     = out_q.wv;
  assign bus.rd_x    = out_q.rd;
  assign bus.rd_data = out_q.data;

endmodule

// File: tb/tb_trace_tap.sv
module tb_trace_tap;
  localparam int DEPTH = 4;

  typedef struct {
    bit          iv;
    bit [31:0]   pc;
    bit [31:0]   inst;
    bit          wv;
    bit [4:0]    rd;
    bit [31:0]   data;
  } mrec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  trace_tap_if bus ();

  trace_tap #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  mrec_t q[$];
  mrec_t exp_out;

`ifdef TRACE_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_out = '{default: 0};
  endtask

  task automatic drive(input bit rv, input bit [31:0] pc, input bit [31:0] inst,
                       input bit rrdv, input bit [4:0] rrd, input bit [31:0] rdata,
                       input bit wv, input bit [4:0] wrd, input bit [31:0] wdata);
    bus.ret_valid = rv;   bus.ret_pc = pc;    bus.ret_inst = inst;
    bus.ret_rdv   = rrdv; bus.ret_rd = rrd;   bus.ret_data = rdata;
    bus.wb_valid  = wv;   bus.wb_rd  = wrd;   bus.wb_data  = wdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   bus.valid,   exp_out.iv);
    chk({tag, ".pc"},      bus.pc,      exp_out.pc);
    chk({tag, ".inst"},    bus.inst,    exp_out.inst);
    chk({tag, ".rdv"},     bus.rdv,     exp_out.wv);
    chk({tag, ".rd_x"},    bus.rd_x,    exp_out.rd);
    chk({tag, ".rd_data"}, bus.rd_data, exp_out.data);
    chk({tag, ".ret_ready"}, bus.ret_ready, (DEPTH - q.size()) >= 2);
    chk({tag, ".wb_ready"},  bus.wb_ready,  (DEPTH - q.size()) >= 2);
  endtask

  // One clock: called at a negedge with inputs already driven; ends at the next negedge.
  task automatic cycle(input string tag);
    mrec_t pushes[$];
    bit    rdy, racc, wwr, rwr;
    rdy  = (DEPTH - q.size()) >= 2;
    racc = bus.ret_valid && rdy;
    wwr  = bus.wb_valid && rdy && !(FILT && bus.wb_rd == 0);
    rwr  = bus.ret_rdv && !(FILT && bus.ret_rd == 0);
    if (racc && wwr && !rwr)
      pushes.push_back('{1, bus.ret_pc, bus.ret_inst, 1, bus.wb_rd, bus.wb_data});
    else begin
      if (wwr) pushes.push_back('{0, 0, 0, 1, bus.wb_rd, bus.wb_data});
      if (racc) pushes.push_back('{1, bus.ret_pc, bus.ret_inst, rwr,
                                   rwr ? bus.ret_rd : 5'd0, rwr ? bus.ret_data : 32'd0});
    end
    @(posedge clk);
    if (q.size() != 0) exp_out = q.pop_front();
    else begin
      exp_out.iv = 0;
      exp_out.wv = 0;
    end
    foreach (pushes[i]) q.push_back(pushes[i]);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset held with every valid high: nothing may enter, outputs zero.
    drive(1, 32'h1234, 32'h5678, 1, 5'd7, 32'h99, 1, 5'd8, 32'h77);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset_hold");
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    check_all("reset_rel");

    // Single retire: not visible after accepting edge, visible after the next.
    drive(1, 32'h80000000, 32'h00500093, 1, 5'd1, 32'd5, 0, 0, 0);
    cycle("single_acc");
    chk("single_lat_valid", bus.valid, 1'b0);
    idle();
    cycle("single_out");
    chk("single_valid", bus.valid, 1'b1);
    chk("single_rd_x", bus.rd_x, 5'd1);
    chk("single_rd_data", bus.rd_data, 32'h5);
    cycle("single_after");
    chk("single_after_valid", bus.valid, 1'b0);
    chk("single_after_rdv", bus.rdv, 1'b0);

    // Merge: retire without write + late wb in the same cycle -> one record.
    drive(1, 32'h80000004, 32'h0000a103, 0, 5'd0, 32'd0, 1, 5'd3, 32'hdeadbeef);
    cycle("merge_acc");
    idle();
    cycle("merge_out");
    chk("merge_valid", bus.valid, 1'b1);
    chk("merge_rd_x", bus.rd_x, 5'd3);
    chk("merge_pc", bus.pc, 32'h80000004);
    cycle("merge_after");
    chk("merge_single_rec", bus.valid, 1'b0);

    // Split: wb record first, then retire record.
    drive(1, 32'h80000008, 32'h01100213, 1, 5'd4, 32'h11, 1, 5'd2, 32'h22);
    cycle("split_acc");
    idle();
    cycle("split_out0");
    chk("split0_valid", bus.valid, 1'b0);
    chk("split0_rd_x", bus.rd_x, 5'd2);
    chk("split0_data", bus.rd_data, 32'h22);
    cycle("split_out1");
    chk("split1_valid", bus.valid, 1'b1);
    chk("split1_rd_x", bus.rd_x, 5'd4);
    chk("split1_data", bus.rd_data, 32'h11);
    cycle("split_after");

    // Back-pressure: five consecutive split cycles.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h80001000 + 32'(i * 4), 32'h00000013 + 32'(i), 1, 5'(10 + i), 32'(100 + i),
            1, 5'(20 + i), 32'(200 + i));
      cycle("bp");
      if (i == 1) chk("bp_ready_low", bus.ret_ready, 1'b0);
    end
    idle();
    repeat (DEPTH + 2) cycle("bp_drain");
    chk("bp_ready_back", bus.ret_ready, 1'b1);
    chk("bp_empty_valid", bus.valid, 1'b0);

    // Writes to x0.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hcafe0000);
    cycle("x0wb_acc");
    idle();
    cycle("x0wb_out");
    chk("x0wb_rdv", bus.rdv, FILT ? 1'b0 : 1'b1);
    drive(1, 32'h80002000, 32'h00100013, 1, 5'd0, 32'd1, 0, 0, 0);
    cycle("x0ret_acc");
    idle();
    cycle("x0ret_out");
    chk("x0ret_valid", bus.valid, 1'b1);
    chk("x0ret_rdv", bus.rdv, FILT ? 1'b0 : 1'b1);
    cycle("x0_after");

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom_range(0, 1),
            5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 9) < 5, 5'($urandom_range(0, 3)), $urandom);
      cycle("rand");
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    drive(1, 32'h80003000, 32'h00000033, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    cycle("mid_fill0");
    cycle("mid_fill1");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    cycle("post_reset");
    chk("post_reset_valid", bus.valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
